// File: rtl/uart_rx_cmd_ctrl.sv
// Command controller behind the UART receiver: parses AA/BB frames into register-file
// writes and reads, and returns read data to the UART transmitter.
module uart_rx_cmd_ctrl #(
    parameter int unsigned           DATA_WIDTH  = 8,
    parameter int unsigned           ADDR_WIDTH  = 4,
    parameter logic [DATA_WIDTH-1:0] CMD_WR      = 8'hAA,
    parameter logic [DATA_WIDTH-1:0] CMD_RD      = 8'hBB,
    parameter logic [15:0]           TIMEOUT_CYC = 16'd4096
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic [DATA_WIDTH-1:0] RF_RD_DATA,
    input  logic                  RF_RD_VLD,
    input  logic                  TX_BUSY,
    output logic [ADDR_WIDTH-1:0] RF_ADDR,
    output logic [DATA_WIDTH-1:0] RF_WR_DATA,
    output logic                  RF_WR_EN,
    output logic                  RF_RD_EN,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    output logic                  CMD_ERR
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StWrAddr = 3'd1;
    localparam logic [2:0] StWrData = 3'd2;
    localparam logic [2:0] StRdAddr = 3'd3;
    localparam logic [2:0] StRdWait = 3'd4;
    localparam logic [2:0] StTxWait = 3'd5;

    // The counter restarts the cycle after an accepted byte, so expiring one count early
    // lands CMD_ERR exactly TIMEOUT_CYC cycles after that byte's strobe.
    localparam logic [15:0] ExpireCnt = TIMEOUT_CYC - 16'd2;

    logic [2:0]            r_state;
    logic [15:0]           r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_wr_en;
    logic                  r_rd_en;
    logic                  r_tx_vld;
    logic                  r_err;

    logic [2:0]            w_state_nxt;
    logic [15:0]           w_cnt_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [DATA_WIDTH-1:0] w_wr_data_nxt;
    logic [DATA_WIDTH-1:0] w_tx_data_nxt;
    logic                  w_wr_en_nxt;
    logic                  w_rd_en_nxt;
    logic                  w_tx_vld_nxt;
    logic                  w_err_nxt;
    logic                  w_timed;
    logic                  w_expire;

    assign w_timed  = (r_state == StWrAddr) || (r_state == StWrData) ||
                      (r_state == StRdAddr) || (r_state == StRdWait);
    assign w_expire = w_timed && (r_cnt == ExpireCnt);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = w_timed ? r_cnt + 16'd1 : 16'd0;
        w_addr_nxt    = r_addr;
        w_wr_data_nxt = r_wr_data;
        w_tx_data_nxt = r_tx_data;
        w_wr_en_nxt   = 1'b0;
        w_rd_en_nxt   = 1'b0;
        w_tx_vld_nxt  = 1'b0;
        w_err_nxt     = 1'b0;

        case (r_state)
            StIdle: begin
                if (RX_D_VLD) begin
                    w_cnt_nxt = 16'd0;
                    if (RX_P_DATA == CMD_WR) begin
                        w_state_nxt = StWrAddr;
                    end else if (RX_P_DATA == CMD_RD) begin
                        w_state_nxt = StRdAddr;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            StWrAddr: begin
                if (RX_D_VLD) begin
                    w_addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
                    w_cnt_nxt   = 16'd0;
                    w_state_nxt = StWrData;
                end else if (w_expire) begin
                    w_err_nxt   = 1'b1;
                    w_cnt_nxt   = 16'd0;
                    w_state_nxt = StIdle;
                end
            end
            StWrData: begin
                if (RX_D_VLD) begin
                    w_wr_data_nxt = RX_P_DATA;
                    w_wr_en_nxt   = 1'b1;
                    w_cnt_nxt     = 16'd0;
                    w_state_nxt   = StIdle;
                end else if (w_expire) begin
                    w_err_nxt   = 1'b1;
                    w_cnt_nxt   = 16'd0;
                    w_state_nxt = StIdle;
                end
            end
            StRdAddr: begin
                if (RX_D_VLD) begin
                    w_addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
                    w_rd_en_nxt = 1'b1;
                    w_cnt_nxt   = 16'd0;
                    w_state_nxt = StRdWait;
                end else if (w_expire) begin
                    w_err_nxt   = 1'b1;
                    w_cnt_nxt   = 16'd0;
                    w_state_nxt = StIdle;
                end
            end
            StRdWait: begin
                // Stray RX bytes are dropped and flagged; they do not restart the timeout.
                if (RX_D_VLD) begin
                    w_err_nxt = 1'b1;
                end
                if (RF_RD_VLD) begin
                    w_tx_data_nxt = RF_RD_DATA;
                    w_cnt_nxt     = 16'd0;
                    w_state_nxt   = StTxWait;
                end else if (w_expire) begin
                    w_err_nxt   = 1'b1;
                    w_cnt_nxt   = 16'd0;
                    w_state_nxt = StIdle;
                end
            end
            StTxWait: begin
                if (RX_D_VLD) begin
                    w_err_nxt = 1'b1;
                end
                if (!TX_BUSY) begin
                    w_tx_vld_nxt = 1'b1;
                    w_state_nxt  = StIdle;
                end
            end
            default: begin
                w_cnt_nxt   = 16'd0;
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= StIdle;
            r_cnt     <= 16'd0;
            r_addr    <= '0;
            r_wr_data <= '0;
            r_tx_data <= '0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_tx_vld  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_addr    <= w_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_tx_data <= w_tx_data_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_rd_en   <= w_rd_en_nxt;
            r_tx_vld  <= w_tx_vld_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign RF_ADDR    = r_addr;
    assign RF_WR_DATA = r_wr_data;
    assign RF_WR_EN   = r_wr_en;
    assign RF_RD_EN   = r_rd_en;
    assign TX_P_DATA  = r_tx_data;
    assign TX_D_VLD   = r_tx_vld;
    assign CMD_ERR    = r_err;

endmodule
